// File: rtl/wb_queue.sv
// Writeback queue: buffers ALU/LSU results in an in-order FIFO and drains
// up to two per cycle onto the register-file write ports.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [4:0]                 alu_rd,
  input  logic [31:0]                alu_data,
  input  logic                       alu_link,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [4:0]                 lsu_rd,
  input  logic [31:0]                lsu_data,
  input  logic                       rf_busy,
  output logic [4:0]                 reg_addr1,
  output logic [4:0]                 reg_addr2,
  output logic [31:0]                wr_data1,
  output logic [31:0]                wr_data2,
  output logic [1:0]                 rdwr_config,
  output logic                       link_reg,
  output logic [31:0]                pending_mask,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  logic [4:0]    q_rd   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic          q_link [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] head0;
  logic [PW-1:0] head1;
  logic [PW-1:0] lsu_wp;
  logic          alu_push;
  logic          lsu_push;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;

  // Ready from registered occupancy only; same-cycle drains are not credited.
  assign alu_ready = (occupancy < OW'(DEPTH));
  assign lsu_ready = (occupancy < OW'(DEPTH - 1));

  // rd = 0 results complete the handshake but are never stored.
  assign alu_push = alu_valid & alu_ready & (alu_rd != 5'd0);
  assign lsu_push = lsu_valid & lsu_ready & (lsu_rd != 5'd0);
  assign push_n   = {1'b0, alu_push} + {1'b0, lsu_push};
  assign lsu_wp   = wr_ptr + PW'(alu_push);
  assign head0    = rd_ptr;
  assign head1    = rd_ptr + PW'(1);

  // Drain decision: pair only distinct rds, and keep link entries on port 1.
  always_comb begin
    pop_n = 2'd0;
    if (!rf_busy && (occupancy != '0)) begin
      if ((occupancy >= OW'(2)) && (q_rd[head0] != q_rd[head1]) && !q_link[head1])
        pop_n = 2'd2;
      else
        pop_n = 2'd1;
    end
  end

  // FIFO storage; entries are invalidated by occupancy, so no reset needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (alu_push) begin
        q_rd[wr_ptr]   <= alu_rd;
        q_data[wr_ptr] <= alu_data;
        q_link[wr_ptr] <= alu_link;
      end
      if (lsu_push) begin
        q_rd[lsu_wp]   <= lsu_rd;
        q_data[lsu_wp] <= lsu_data;
        q_link[lsu_wp] <= 1'b0;
      end
    end
  end

  // Pointer/occupancy bookkeeping and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occupancy   <= '0;
      reg_addr1   <= '0;
      reg_addr2   <= '0;
      wr_data1    <= '0;
      wr_data2    <= '0;
      rdwr_config <= 2'b00;
      link_reg    <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr + PW'(pop_n);
      wr_ptr    <= wr_ptr + PW'(push_n);
      occupancy <= occupancy + OW'(push_n) - OW'(pop_n);
      case (pop_n)
        2'd2: begin
          reg_addr1   <= q_rd[head0];
          wr_data1    <= q_data[head0];
          link_reg    <= q_link[head0];
          reg_addr2   <= q_rd[head1];
          wr_data2    <= q_data[head1];
          rdwr_config <= 2'b11;
        end
        2'd1: begin
          reg_addr1   <= q_rd[head0];
          wr_data1    <= q_data[head0];
          link_reg    <= q_link[head0];
          reg_addr2   <= '0;
          wr_data2    <= '0;
          rdwr_config <= 2'b01;
        end
        default: begin
          reg_addr1   <= '0;
          wr_data1    <= '0;
          link_reg    <= 1'b0;
          reg_addr2   <= '0;
          wr_data2    <= '0;
          rdwr_config <= 2'b00;
        end
      endcase
    end
  end

  // Pending destinations: every valid FIFO entry plus any live write port.
  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (OW'(i) < occupancy)
        pending_mask[q_rd[rd_ptr + PW'(i)]] = 1'b1;
    end
    if (rdwr_config[0]) pending_mask[reg_addr1] = 1'b1;
    if (rdwr_config[1]) pending_mask[reg_addr2] = 1'b1;
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: scoreboard of expected writes consumed
// by a port monitor, plus per-scenario cycle-accurate checks.
module tb_wb_queue;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_link;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        rf_busy;
  logic [4:0]  reg_addr1;
  logic [4:0]  reg_addr2;
  logic [31:0] wr_data1;
  logic [31:0] wr_data2;
  logic [1:0]  rdwr_config;
  logic        link_reg;
  logic [31:0] pending_mask;
  logic [2:0]  occupancy;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        link;
  } wr_t;

  wr_t sb[$];
  wr_t e;
  int  total = 0;
  int  bad   = 0;

  wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
    .alu_data(alu_data), .alu_link(alu_link),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
    .lsu_data(lsu_data), .rf_busy(rf_busy),
    .reg_addr1(reg_addr1), .reg_addr2(reg_addr2),
    .wr_data1(wr_data1), .wr_data2(wr_data2),
    .rdwr_config(rdwr_config), .link_reg(link_reg),
    .pending_mask(pending_mask), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_alu(input logic [4:0] rd, input logic [31:0] data, input logic link);
    alu_valid = 1'b1; alu_rd = rd; alu_data = data; alu_link = link;
  endtask

  task automatic push_lsu(input logic [4:0] rd, input logic [31:0] data);
    lsu_valid = 1'b1; lsu_rd = rd; lsu_data = data;
  endtask

  task automatic idle();
    alu_valid = 1'b0; lsu_valid = 1'b0; alu_link = 1'b0;
  endtask

  // Scoreboard consumer: every enabled write port must match the next expected write.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (rdwr_config[0] === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL port1_unexpected got addr=%0d data=%h", reg_addr1, wr_data1);
        end else begin
          e = sb.pop_front();
          if (reg_addr1 !== e.rd || wr_data1 !== e.data || link_reg !== e.link) begin
            bad++;
            $display("FAIL port1_write got %0d/%h/%b want %0d/%h/%b",
                     reg_addr1, wr_data1, link_reg, e.rd, e.data, e.link);
          end
        end
      end
      if (rdwr_config[1] === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL port2_unexpected got addr=%0d data=%h", reg_addr2, wr_data2);
        end else begin
          e = sb.pop_front();
          if (reg_addr2 !== e.rd || wr_data2 !== e.data) begin
            bad++;
            $display("FAIL port2_write got %0d/%h want %0d/%h",
                     reg_addr2, wr_data2, e.rd, e.data);
          end
        end
      end else begin
        total++;
        if (reg_addr2 !== 5'd0 || wr_data2 !== 32'd0) begin
          bad++;
          $display("FAIL port2_idle got %0d/%h want 0/0", reg_addr2, wr_data2);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0; rf_busy = 1'b0;
    push_alu(5'd9, 32'h1234, 1'b0);
    push_lsu(5'd10, 32'h5678);
    step(); step();
    total++;
    if ({rdwr_config, reg_addr1, reg_addr2, wr_data1, wr_data2, link_reg, occupancy, pending_mask} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got cfg=%b a1=%0d a2=%0d occ=%0d pm=%h want all 0",
               rdwr_config, reg_addr1, reg_addr2, occupancy, pending_mask);
    end
    idle();
    rst = 1'b1;
    step();
    total++;
    if (alu_ready !== 1'b1 || lsu_ready !== 1'b1 || occupancy !== 3'd0) begin
      bad++;
      $display("FAIL reset_ready got alu=%b lsu=%b occ=%0d want 1 1 0", alu_ready, lsu_ready, occupancy);
    end
  endtask

  task automatic test_single();
    push_alu(5'd5, 32'hDEADBEEF, 1'b0);
    sb.push_back('{5'd5, 32'hDEADBEEF, 1'b0});
    step(); idle();
    total++;
    if (pending_mask !== 32'h20 || occupancy !== 3'd1 || rdwr_config !== 2'b00) begin
      bad++;
      $display("FAIL single_e got pm=%h occ=%0d cfg=%b want 20 1 00", pending_mask, occupancy, rdwr_config);
    end
    step();
    total++;
    if (rdwr_config !== 2'b01 || reg_addr1 !== 5'd5 || wr_data1 !== 32'hDEADBEEF || pending_mask !== 32'h20) begin
      bad++;
      $display("FAIL single_e1 got cfg=%b a1=%0d d1=%h pm=%h want 01 5 deadbeef 20",
               rdwr_config, reg_addr1, wr_data1, pending_mask);
    end
    step();
    total++;
    if (rdwr_config !== 2'b00 || pending_mask !== 32'h0) begin
      bad++;
      $display("FAIL single_e2 got cfg=%b pm=%h want 00 0", rdwr_config, pending_mask);
    end
  endtask

  task automatic test_dual();
    push_alu(5'd3, 32'd1, 1'b0);
    push_lsu(5'd4, 32'd2);
    sb.push_back('{5'd3, 32'd1, 1'b0});
    sb.push_back('{5'd4, 32'd2, 1'b0});
    step(); idle();
    total++;
    if (occupancy !== 3'd2 || pending_mask !== 32'h18) begin
      bad++;
      $display("FAIL dual_queued got occ=%0d pm=%h want 2 18", occupancy, pending_mask);
    end
    step();
    total++;
    if (rdwr_config !== 2'b11 || reg_addr1 !== 5'd3 || wr_data1 !== 32'd1 ||
        reg_addr2 !== 5'd4 || wr_data2 !== 32'd2) begin
      bad++;
      $display("FAIL dual_write got cfg=%b %0d/%h %0d/%h want 11 3/1 4/2",
               rdwr_config, reg_addr1, wr_data1, reg_addr2, wr_data2);
    end
    step();
  endtask

  task automatic test_same_rd();
    push_alu(5'd7, 32'hA, 1'b0);
    push_lsu(5'd7, 32'hB);
    sb.push_back('{5'd7, 32'hA, 1'b0});
    sb.push_back('{5'd7, 32'hB, 1'b0});
    step(); idle();
    step();
    total++;
    if (rdwr_config !== 2'b01 || wr_data1 !== 32'hA) begin
      bad++;
      $display("FAIL same_rd_first got cfg=%b d1=%h want 01 a", rdwr_config, wr_data1);
    end
    step();
    total++;
    if (rdwr_config !== 2'b01 || wr_data1 !== 32'hB) begin
      bad++;
      $display("FAIL same_rd_second got cfg=%b d1=%h want 01 b", rdwr_config, wr_data1);
    end
    step();
  endtask

  task automatic test_link();
    // Link entry as second-oldest must not pair onto port 2.
    rf_busy = 1'b1;
    push_alu(5'd2, 32'h22, 1'b0);
    sb.push_back('{5'd2, 32'h22, 1'b0});
    step();
    push_alu(5'd1, 32'h11, 1'b1);
    sb.push_back('{5'd1, 32'h11, 1'b1});
    step(); idle();
    rf_busy = 1'b0;
    step();
    total++;
    if (rdwr_config !== 2'b01 || reg_addr1 !== 5'd2 || link_reg !== 1'b0) begin
      bad++;
      $display("FAIL link_pair_split got cfg=%b a1=%0d lk=%b want 01 2 0", rdwr_config, reg_addr1, link_reg);
    end
    step();
    total++;
    if (rdwr_config !== 2'b01 || reg_addr1 !== 5'd1 || link_reg !== 1'b1) begin
      bad++;
      $display("FAIL link_port1 got cfg=%b a1=%0d lk=%b want 01 1 1", rdwr_config, reg_addr1, link_reg);
    end
    step();
    total++;
    if (link_reg !== 1'b0 || rdwr_config !== 2'b00) begin
      bad++;
      $display("FAIL link_clear got lk=%b cfg=%b want 0 00", link_reg, rdwr_config);
    end
  endtask

  task automatic test_backpressure();
    int occ_m;
    occ_m = 0;
    rf_busy = 1'b1;
    for (int r = 1; r <= 6; r++) begin
      push_alu(5'(r), 32'(r * 256), 1'b0);
      #1;
      total++;
      if (alu_ready !== (occ_m < 4) || lsu_ready !== (occ_m <= 2)) begin
        bad++;
        $display("FAIL bp_ready rd=%0d got alu=%b lsu=%b want %b %b",
                 r, alu_ready, lsu_ready, occ_m < 4, occ_m <= 2);
      end
      if (occ_m < 4) begin
        sb.push_back('{5'(r), 32'(r * 256), 1'b0});
        occ_m++;
      end
      step();
    end
    idle();
    total++;
    if (occupancy !== 3'd4 || pending_mask !== 32'h1E) begin
      bad++;
      $display("FAIL bp_full got occ=%0d pm=%h want 4 1e", occupancy, pending_mask);
    end
    rf_busy = 1'b0;
    step();
    total++;
    if (rdwr_config !== 2'b11 || reg_addr1 !== 5'd1 || reg_addr2 !== 5'd2 || occupancy !== 3'd2) begin
      bad++;
      $display("FAIL bp_drain1 got cfg=%b a1=%0d a2=%0d occ=%0d want 11 1 2 2",
               rdwr_config, reg_addr1, reg_addr2, occupancy);
    end
    step();
    total++;
    if (rdwr_config !== 2'b11 || reg_addr1 !== 5'd3 || reg_addr2 !== 5'd4 || occupancy !== 3'd0) begin
      bad++;
      $display("FAIL bp_drain2 got cfg=%b a1=%0d a2=%0d occ=%0d want 11 3 4 0",
               rdwr_config, reg_addr1, reg_addr2, occupancy);
    end
    step();
  endtask

  task automatic test_rd_zero();
    push_alu(5'd0, 32'h55, 1'b0);
    #1;
    total++;
    if (alu_ready !== 1'b1) begin
      bad++;
      $display("FAIL rd0_ready got %b want 1", alu_ready);
    end
    step(); idle();
    total++;
    if (occupancy !== 3'd0 || pending_mask !== 32'h0) begin
      bad++;
      $display("FAIL rd0_occ got occ=%0d pm=%h want 0 0", occupancy, pending_mask);
    end
    step();
    total++;
    if (rdwr_config !== 2'b00) begin
      bad++;
      $display("FAIL rd0_cfg got %b want 00", rdwr_config);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] da, dl;
    for (int k = 0; k < 6; k++) begin
      da = $urandom; dl = $urandom;
      push_alu(5'(8 + k), da, 1'b0);
      push_lsu(5'(16 + k), dl);
      #1;
      total++;
      if (alu_ready !== 1'b1 || lsu_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready k=%0d got alu=%b lsu=%b want 1 1", k, alu_ready, lsu_ready);
      end
      sb.push_back('{5'(8 + k), da, 1'b0});
      sb.push_back('{5'(16 + k), dl, 1'b0});
      step();
      if (k >= 1) begin
        total++;
        if (rdwr_config !== 2'b11) begin
          bad++;
          $display("FAIL b2b_rate k=%0d got cfg=%b want 11", k, rdwr_config);
        end
      end
    end
    idle();
    cyc = 0;
    while (occupancy !== 3'd0 && cyc < 20) begin
      step();
      cyc++;
    end
    total++;
    if (cyc >= 20) begin
      bad++;
      $display("FAIL b2b_drain_timeout got occ=%0d want 0", occupancy);
    end
    step(); step();
  endtask

  task automatic test_reset_mid_drain();
    push_alu(5'd12, 32'hC, 1'b0);
    push_lsu(5'd13, 32'hD);
    step(); idle();
    rst = 1'b0;
    step();
    total++;
    if (rdwr_config !== 2'b00 || occupancy !== 3'd0 || pending_mask !== 32'h0 ||
        reg_addr1 !== 5'd0 || wr_data1 !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid got cfg=%b occ=%0d pm=%h a1=%0d want 00 0 0 0",
               rdwr_config, occupancy, pending_mask, reg_addr1);
    end
    rst = 1'b1;
    step(); step();
  endtask

  initial begin
    rst = 1'b0; rf_busy = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0; alu_link = 1'b0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    test_reset();
    test_single();
    test_dual();
    test_same_rd();
    test_link();
    test_backpressure();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid_drain();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
